// File: rtl/phase_launcher_pkg.sv
// phase_launcher_pkg: shared state encoding and default widths for the phase launcher.
package phase_launcher_pkg;
  localparam int PHASE_W_DEF = 8;
  localparam int TIMEOUT_W_DEF = 16;
  typedef enum logic [1:0] {
    LS_IDLE  = 2'd0,
    LS_START = 2'd1,
    LS_WAIT  = 2'd2,
    LS_DONE  = 2'd3
  } launch_state_t;
endpackage

// File: rtl/phase_launcher_if.sv
// phase_launcher_if: launch handshake and core array signals; master is host/cores, slave is the launcher.
interface phase_launcher_if
  import phase_launcher_pkg::*;
#(
  parameter int NUM_CORES = 1,
  parameter int PHASE_W = PHASE_W_DEF
);
  logic launch_valid;
  logic launch_ready;
  logic [PHASE_W-1:0] launch_phases;
  logic [NUM_CORES-1:0] launch_mask;
  logic [NUM_CORES-1:0] core_start;
  logic [PHASE_W-1:0] core_phase;
  logic [NUM_CORES-1:0] core_done;
  logic busy;
  logic kernel_done;
  logic timeout_err;
  modport master (
    output launch_valid, launch_phases, launch_mask, core_done,
    input  launch_ready, core_start, core_phase, busy, kernel_done, timeout_err
  );
  modport slave (
    input  launch_valid, launch_phases, launch_mask, core_done,
    output launch_ready, core_start, core_phase, busy, kernel_done, timeout_err
  );
endinterface

// File: rtl/phase_launcher_done_collector.sv
// done_collector: per-phase completion barrier, masked OR-accumulate with full-compare flag.
module done_collector #(
  parameter int NUM_CORES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic [NUM_CORES-1:0] mask,
  input  logic [NUM_CORES-1:0] done,
  output logic full
);
  logic [NUM_CORES-1:0] acc;
  always_ff @(posedge clk)
    if (rst || clr) acc <= '0;
    else if (en) acc <= acc | (done & mask);
  assign full = acc == mask;
endmodule

// File: rtl/phase_launcher.sv
// phase_launcher: kernel phase sequencer with per-phase core barrier.
// Optional per-phase watchdog enabled by PHASE_LAUNCHER_TIMEOUT_EN.
module phase_launcher
  import phase_launcher_pkg::*;
#(
  parameter int NUM_CORES = 1,
  parameter int PHASE_W = PHASE_W_DEF
`ifdef PHASE_LAUNCHER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
`endif
) (
  input logic clk,
  input logic rst,
  phase_launcher_if.slave bus
);
  launch_state_t state;
  logic [NUM_CORES-1:0] mask_q;
  logic [PHASE_W-1:0] phases_q, phase_q, last;
  logic accept, full, expire;
  assign accept = state == LS_IDLE && bus.launch_valid;
  assign last = phases_q - PHASE_W'(1);
  done_collector #(.NUM_CORES(NUM_CORES)) u_done (
    .clk(clk),
    .rst(rst),
    .clr(state == LS_START),
    .en(state == LS_WAIT),
    .mask(mask_q),
    .done(bus.core_done),
    .full(full)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= LS_IDLE;
      mask_q <= '0;
      phases_q <= '0;
      phase_q <= '0;
    end else
      case (state)
        LS_IDLE:
          if (bus.launch_valid) begin
            mask_q <= bus.launch_mask;
            phases_q <= bus.launch_phases;
            phase_q <= '0;
            state <= bus.launch_phases == '0 ? LS_DONE : LS_START;
          end
        LS_START: state <= LS_WAIT;
        LS_WAIT:
          if (full) begin
            // Check against the last index before incrementing so a full-range count never wraps.
            if (phase_q == last) state <= LS_DONE;
            else begin
              phase_q <= phase_q + PHASE_W'(1);
              state <= LS_START;
            end
          end else if (expire) state <= LS_DONE;
        default: state <= LS_IDLE;
      endcase
`ifdef PHASE_LAUNCHER_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] wd;
  logic terr;
  always_ff @(posedge clk)
    if (rst || state == LS_START) wd <= '0;
    else if (state == LS_WAIT && wd != '1) wd <= wd + TIMEOUT_W'(1);
  // Expire on the WAIT cycle whose count step lands on saturation.
  assign expire = state == LS_WAIT && !full && wd == WD_LAST;
  always_ff @(posedge clk)
    if (rst || accept) terr <= 1'b0;
    else if (expire) terr <= 1'b1;
  assign bus.timeout_err = terr;
`else
  assign expire = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  assign bus.launch_ready = state == LS_IDLE;
  assign bus.core_start = state == LS_START ? mask_q : '0;
  assign bus.core_phase = phase_q;
  assign bus.busy = state != LS_IDLE;
  assign bus.kernel_done = state == LS_DONE;
endmodule

// File: tb/tb_phase_launcher.sv
// tb_phase_launcher: directed vectors with hand-computed cycle expectations for phase_launcher.
module tb_phase_launcher;
  localparam int NC = 4;
  localparam int PW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  phase_launcher_if #(.NUM_CORES(NC), .PHASE_W(PW)) bus ();
  phase_launcher #(
    .NUM_CORES(NC),
    .PHASE_W(PW)
`ifdef PHASE_LAUNCHER_TIMEOUT_EN
    ,
    .TIMEOUT_W(4)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [PW-1:0] ph, input logic [NC-1:0] m);
    bus.launch_valid = 1'b1;
    bus.launch_phases = ph;
    bus.launch_mask = m;
    step;
    bus.launch_valid = 1'b0;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, " ready"}, bus.launch_ready, 1);
    chk({tag, " start"}, bus.core_start, 0);
    chk({tag, " phase"}, bus.core_phase, 0);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " kdone"}, bus.kernel_done, 0);
    chk({tag, " terr"}, bus.timeout_err, 0);
  endtask
  initial begin
    bus.launch_valid = 1'b0;
    bus.launch_phases = '0;
    bus.launch_mask = '0;
    bus.core_done = '0;
    step;
    step;
    idle_chk("rst");
    rst = 1'b0;
    step;
    // single phase, all four cores, done at +3, +5, +5, +8
    launch(8'd1, 4'b1111);
    for (int c = 1; c <= 11; c++) begin
      bus.core_done = c == 3 ? 4'b0001 : c == 5 ? 4'b0110 : c == 8 ? 4'b1000 : 4'b0000;
      chk($sformatf("t1 start c%0d", c), bus.core_start, c == 1 ? 4'b1111 : 4'b0000);
      chk($sformatf("t1 kdone c%0d", c), bus.kernel_done, c == 10);
      chk($sformatf("t1 busy c%0d", c), bus.busy, c <= 10);
      step;
    end
    bus.core_done = '0;
    // three phases, mask 0101, done two cycles after each start
    launch(8'd3, 4'b0101);
    for (int c = 1; c <= 14; c++) begin
      bus.core_done = (c == 3 || c == 7 || c == 11) ? 4'b0101 : 4'b0000;
      chk($sformatf("t2 start c%0d", c), bus.core_start, (c == 1 || c == 5 || c == 9) ? 4'b0101 : 4'b0000);
      if (c == 1 || c == 5 || c == 9) chk($sformatf("t2 phase c%0d", c), bus.core_phase, (c - 1) / 4);
      chk($sformatf("t2 kdone c%0d", c), bus.kernel_done, c == 13);
      step;
    end
    bus.core_done = '0;
    // zero phases
    launch(8'd0, 4'b1111);
    chk("t3 kdone", bus.kernel_done, 1);
    chk("t3 start", bus.core_start, 0);
    chk("t3 busy", bus.busy, 1);
    step;
    chk("t3 ready", bus.launch_ready, 1);
    // empty mask, two phases
    launch(8'd2, 4'b0000);
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("t3m kdone c%0d", c), bus.kernel_done, c == 5);
      chk($sformatf("t3m start c%0d", c), bus.core_start, 0);
      if (c == 3) chk("t3m phase", bus.core_phase, 1);
      chk($sformatf("t3m busy c%0d", c), bus.busy, c <= 5);
      step;
    end
    // spurious done outside mask is ignored
    launch(8'd1, 4'b0101);
    for (int c = 1; c <= 11; c++) begin
      bus.core_done = c == 3 ? 4'b1010 : c == 6 ? 4'b0001 : c == 8 ? 4'b0100 : 4'b0000;
      chk($sformatf("t4 kdone c%0d", c), bus.kernel_done, c == 10);
      step;
    end
    bus.core_done = '0;
    // reset during WAIT of phase 1
    launch(8'd3, 4'b0001);
    for (int c = 1; c <= 6; c++) begin
      bus.core_done = c == 3 ? 4'b0001 : 4'b0000;
      if (c == 5) chk("t5 phase1", bus.core_phase, 1);
      if (c < 6) step;
    end
    bus.core_done = '0;
    rst = 1'b1;
    step;
    idle_chk("t5 rst");
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t5 no kdone %0d", c), bus.kernel_done, 0);
      step;
    end
    launch(8'd1, 4'b0001);
    for (int c = 1; c <= 6; c++) begin
      bus.core_done = c == 3 ? 4'b0001 : 4'b0000;
      chk($sformatf("t5r start c%0d", c), bus.core_start, c == 1 ? 4'b0001 : 4'b0000);
      if (c == 1) chk("t5r phase", bus.core_phase, 0);
      chk($sformatf("t5r kdone c%0d", c), bus.kernel_done, c == 5);
      step;
    end
    bus.core_done = '0;
`ifdef PHASE_LAUNCHER_TIMEOUT_EN
    // core 2 never finishes; 15 WAIT cycles then watchdog DONE
    launch(8'd1, 4'b0100);
    for (int c = 1; c <= 18; c++) begin
      chk($sformatf("t6 kdone c%0d", c), bus.kernel_done, c == 17);
      chk($sformatf("t6 terr c%0d", c), bus.timeout_err, c >= 17);
      if (c < 18) step;
    end
    launch(8'd0, 4'b0000);
    chk("t6 terr clr", bus.timeout_err, 0);
    step;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/phase_launcher.md
# phase_launcher

Kernel phase sequencer for the multi-core GPU array: accepts a launch request, pulses per-core start for each phase, collects per-core completion, and releases the next phase only when every participating core has finished. It drives the cores that feed the completion barrier, and it implements that barrier internally for its own release decisions. It sits between the host/command front end and the core array.

## Interface
- `NUM_CORES`, 1: number of cores driven/monitored.
- `PHASE_W`, 8: width of phase count and phase index.
- `TIMEOUT_W`, 16: width of the per-phase watchdog counter (used only with the macro).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `launch_valid`  in  1  launch request present.
- `launch_ready`  out  1  high only in IDLE.
- `launch_phases`  in  PHASE_W  number of phases; sampled on accept.
- `launch_mask`  in  NUM_CORES  participating cores; sampled on accept.
- `core_start`  out  NUM_CORES  one-cycle start pulse, equal to the latched mask.
- `core_phase`  out  PHASE_W  current phase index, 0-based; valid while `busy`.
- `core_done`  in  NUM_CORES  completion pulse or level per core.
- `busy`  out  1  high from accept through the DONE cycle.
- `kernel_done`  out  1  one-cycle pulse at kernel end.
- `timeout_err`  out  1  sticky watchdog flag; constant 0 without the macro.

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE: `launch_ready`=1. On `launch_valid`: latch mask, phases, `core_phase`<=0, clear `timeout_err`. Go to DONE if phases==0, else START.
- START, exactly one cycle: `core_start`=mask; clear done accumulator; clear watchdog. Then go to WAIT.
- WAIT: accumulator <= accumulator | (`core_done` & mask). Bits outside the mask are ignored. `core_done` is ignored in START and DONE.
- WAIT exit: taken when the registered accumulator equals the mask.
  - If `core_phase`==phases-1, go to DONE.
  - Otherwise increment `core_phase` and go to START.
- mask==0: every phase completes with no core activity; START then one WAIT cycle per phase.
- DONE, one cycle: `kernel_done`=1. Then go to IDLE.
- Phase arithmetic: unsigned PHASE_W. The maximum of 2^PHASE_W-1 phases never wraps, because the exit check occurs before the increment.
- `rst` in any state: state IDLE, all registers cleared; no `kernel_done` is produced for an aborted kernel.

## Timing
- Reset values: `launch_ready`=1, `core_start`=0, `core_phase`=0, `busy`=0, `kernel_done`=0, `timeout_err`=0.
- Accept at cycle T, phases≥1: `core_start` at T+1.
- Last required `core_done` sampled at cycle t: accumulator full at t+1; next `core_start` or `kernel_done` at t+2.
- Phase overhead is 3 cycles beyond the slowest core.
- A done pulse arriving in the same cycle as the START pulse is lost. Cores must not signal done earlier than one cycle after start.

## Configuration
- `PHASE_LAUNCHER_TIMEOUT_EN` defined:
  - A watchdog counts WAIT cycles and saturates at 2^TIMEOUT_W-1.
  - On reaching the saturation value: set `timeout_err`, go to DONE, pulse `kernel_done`.
  - `timeout_err` holds until the next accepted launch or `rst`.
- Undefined: no counter is built; `timeout_err` is tied to 0; WAIT exits only on full completion.

## Structure
- `phase_launcher_pkg` holds:
  - the state enum `launch_state_t`;
  - default constants for `PHASE_W` and `TIMEOUT_W`.
- One sub-module, `done_collector`. It contains the clear, the masked OR-accumulate, and the full-compare flag. The FSM and counters stay in the top.

## Test plan
- NUM_CORES=4, phases=1, mask=4'b1111. Cores done at T+3,+5,+5,+8 → single `core_start`=1111 at T+1; `kernel_done` at T+10; `busy` low at T+11.
- phases=3, mask=4'b0101, all done 2 cycles after each start → `core_phase` 0,1,2 on successive starts; no `core_start` reaches cores 1/3; exactly one `kernel_done`.
- phases=0 → accept, `kernel_done` on the next cycle, no `core_start`. Separately, mask=0 with phases=2 → two empty start pulses, then `kernel_done`.
- Spurious `core_done`=1010 during WAIT with mask=0101 → no phase advance until bits 0 and 2 arrive.
- `rst` asserted mid-WAIT of phase 1 → next cycle IDLE with all outputs at reset values; a new launch runs cleanly from phase 0.
- With `PHASE_LAUNCHER_TIMEOUT_EN` and TIMEOUT_W=4, core 2 never done → `kernel_done` with `timeout_err`=1 after 15 WAIT cycles; the flag clears on the next accept.
